// File: rtl/sa_ctrl_if.sv
// sa_ctrl_if: controller-side bus of the systolic-array sequencer.
//   master : job source plus array side (drives start/num_vec/abort/res_valid)
//   slave  : sa_ctrl (drives weight/activation reads, array enables, status)
// Signals:
//   start, num_vec[7:0], abort   job request, vector count, synchronous kill
//   res_valid                    bottom-row result vector valid
//   w_rd_en, w_addr, w_load_row  weight-row read and per-row load strobe
//   a_rd_en, a_addr[7:0]         activation-vector read
//   arr_en, en_left[N-1:0]       PE pipeline enable and skewed row valids
//   busy, done, err              job status
interface sa_ctrl_if #(
  parameter int N = 4
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic [7:0]    num_vec;
  logic          abort;
  logic          res_valid;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [N-1:0]  w_load_row;
  logic          a_rd_en;
  logic [7:0]    a_addr;
  logic          arr_en;
  logic [N-1:0]  en_left;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, num_vec, abort, res_valid,
    input  w_rd_en, w_addr, w_load_row, a_rd_en, a_addr, arr_en, en_left,
           busy, done, err
  );

  modport slave (
    input  start, num_vec, abort, res_valid,
    output w_rd_en, w_addr, w_load_row, a_rd_en, a_addr, arr_en, en_left,
           busy, done, err
  );
endinterface

// File: rtl/sa_ctrl.sv
// sa_ctrl: job sequencer for an N x N systolic array. Loads one weight row
// per PE row, streams NUM_VEC activation vectors with per-row skew, then
// waits for all result vectors or a drain timeout.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset
//   io_bus  sa_ctrl_if slave modport (see interface header)
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for START
// S_LOAD_W | N weight-row reads, plus one cycle for the last load strobe
// S_STREAM | one activation read per cycle, NUM_VEC cycles
// S_DRAIN  | waiting for remaining results, bounded by TMO
// S_FINISH | one-cycle DONE (ERR set if the drain timed out)
module sa_ctrl #(
  parameter int N   = 4,
  parameter int TMO = 4*N + 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  sa_ctrl_if.slave io_bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int SL = 2*N - 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  localparam logic [7:0]    N_IDX  = 8'(N);
  localparam logic [TW-1:0] TMO_LD = TW'(TMO - 1);
  localparam logic [N-1:0]  ROW0   = N'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [7:0]    r_idx;
  logic [7:0]    r_num;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_tmr;
  logic          r_err;
  logic [N-1:0]  r_wload;
  logic [SL-1:0] r_skew;
  logic          w_fin_err;
  logic          w_accept;
  logic          w_w_rd;
  logic          w_a_rd;
  logic          w_cnt_hit;

  assign w_accept  = (r_state == S_IDLE) && io_bus.start && !io_bus.abort;
  assign w_w_rd    = (r_state == S_LOAD_W) && (r_idx < N_IDX);
  assign w_a_rd    = (r_state == S_STREAM);
  // A result arriving in the current cycle already counts toward completion.
  assign w_cnt_hit = (r_cnt == r_num) ||
                     (io_bus.res_valid && ((r_cnt + 8'd1) == r_num));

  always_comb begin
    w_state_nxt = r_state;
    w_fin_err   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LOAD_W;
      S_LOAD_W: if (r_idx == N_IDX)
                  w_state_nxt = (r_num == 8'd0) ? S_FINISH : S_STREAM;
      S_STREAM: if (r_idx == (r_num - 8'd1)) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_cnt_hit) begin
          w_state_nxt = S_FINISH;
        end else if (r_tmr == '0) begin
          w_state_nxt = S_FINISH;
          w_fin_err   = 1'b1;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (io_bus.abort) begin
      w_state_nxt = S_IDLE;
      w_fin_err   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_err   <= 1'b0;
      r_wload <= '0;
      r_skew  <= '0;
    end else if (io_bus.abort) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_err   <= 1'b0;
      r_wload <= '0;
      r_skew  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_fin_err;
      // weight data returns one cycle after the read, so the strobe lags it
      r_wload <= w_w_rd ? (ROW0 << r_idx[AW-1:0]) : '0;
      // tap 2r feeds row r: one cycle read latency plus two per row hop
      r_skew  <= SL'({r_skew, w_a_rd});

      if (w_state_nxt != r_state)
        r_idx <= '0;
      else if ((r_state == S_LOAD_W) || (r_state == S_STREAM))
        r_idx <= r_idx + 8'd1;

      if (w_accept) begin
        r_num <= io_bus.num_vec;
        r_cnt <= '0;
      end else if (((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                   io_bus.res_valid && (r_cnt != r_num)) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN))
        r_tmr <= TMO_LD;
      else if ((r_state == S_DRAIN) && (r_tmr != '0))
        r_tmr <= r_tmr - TW'(1);
    end
  end

  assign io_bus.w_rd_en    = w_w_rd;
  assign io_bus.w_addr     = w_w_rd ? r_idx[AW-1:0] : '0;
  assign io_bus.w_load_row = r_wload;
  assign io_bus.a_rd_en    = w_a_rd;
  assign io_bus.a_addr     = w_a_rd ? r_idx : 8'd0;
  assign io_bus.arr_en     = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.done       = (r_state == S_FINISH);
  assign io_bus.err        = (r_state == S_FINISH) && r_err;

  for (genvar g = 0; g < N; g++) begin : g_en_left
    assign io_bus.en_left[g] = r_skew[2*g];
  end
endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: scoreboard bench for sa_ctrl (N=4, default TMO=24).
// Each job test fills stimulus bitmaps, pushes the expected packed output
// vector for every cycle into a queue, then pops and compares per cycle.
module tb_sa_ctrl;
  localparam int N     = 4;
  localparam int TMO   = 24;
  localparam int NOKIL = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sa_ctrl_if #(.N(N)) bus ();
  sa_ctrl #(.N(N)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   m_n;
  int   m_done;
  int   m_kill;
  logic m_err;
  logic res_at   [0:1023];
  logic start_at [0:1023];
  logic abort_at [0:1023];
  logic [23:0] exp_q [$];

  logic [23:0] obs;
  assign obs = {bus.w_rd_en, bus.w_addr, bus.w_load_row, bus.a_rd_en,
                bus.a_addr, bus.arr_en, bus.en_left, bus.busy, bus.done,
                bus.err};

  // Expected outputs in cycle c of a job whose START was sampled in cycle 0.
  function automatic logic [23:0] exp_obs(input int c);
    logic       wr = 1'b0;
    logic [1:0] wa = '0;
    logic [3:0] wl = '0;
    logic       ar = 1'b0;
    logic [7:0] aa = '0;
    logic       ae = 1'b0;
    logic [3:0] el = '0;
    logic       b, d, e;
    if (c > m_kill) return '0;
    if (c >= 1 && c <= N) begin
      wr = 1'b1;
      wa = 2'(c - 1);
    end
    if (c >= 2 && c <= N + 1) wl = 4'(1 << (c - 2));
    if (m_n > 0) begin
      if (c >= N + 2 && c <= N + 1 + m_n) begin
        ar = 1'b1;
        aa = 8'(c - N - 2);
      end
      ae = (c >= N + 2) && (c < m_done);
      for (int r = 0; r < N; r++)
        el[r] = (c >= N + 3 + 2*r) && (c <= N + 2 + m_n + 2*r);
    end
    b = (c >= 1) && (c <= m_done);
    d = (c == m_done);
    e = d && m_err;
    return {wr, wa, wl, ar, aa, ae, el, b, d, e};
  endfunction

  task automatic setup_job(input int n, input int kill);
    m_n    = n;
    m_kill = kill;
    for (int i = 0; i < 1024; i++) begin
      res_at[i]   = 1'b0;
      start_at[i] = 1'b0;
      abort_at[i] = 1'b0;
    end
    start_at[0] = 1'b1;
    if (kill >= 0 && kill < 1024) abort_at[kill] = 1'b1;
    exp_q.delete();
  endtask

  // Completion cycle from the result schedule: results count from the first
  // STREAM cycle on, completion is only checked from DRAIN entry.
  task automatic model_done();
    int cnt = 0;
    int d0;
    if (m_n == 0) begin
      m_done = N + 2;
      m_err  = 1'b0;
      return;
    end
    d0 = N + 2 + m_n;
    for (int t = N + 2; t < d0 + TMO; t++) begin
      if (res_at[t] && cnt < m_n) cnt++;
      if (t >= d0 && cnt >= m_n) begin
        m_done = t + 1;
        m_err  = 1'b0;
        return;
      end
    end
    m_done = d0 + TMO;
    m_err  = 1'b1;
  endtask

  task automatic push_expected(input int last);
    for (int c = 1; c <= last; c++) exp_q.push_back(exp_obs(c));
  endtask

  task automatic drive(input int c);
    bus.start     = start_at[c];
    bus.abort     = abort_at[c];
    bus.res_valid = res_at[c];
    bus.num_vec   = (c == 0) ? 8'(m_n) : 8'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", obs, 24'h0);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== 24'h0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, 24'h0);
      end
    end
  endtask

  task automatic test_basic();
    logic [23:0] e;
    setup_job(3, NOKIL);
    res_at[3]  = 1'b1;   // LOAD_W: ignored
    start_at[4] = 1'b1;  // START while busy: ignored
    res_at[16] = 1'b1;
    res_at[17] = 1'b1;
    res_at[18] = 1'b1;
    res_at[19] = 1'b1;   // 4th pulse in FINISH: ignored
    model_done();
    push_expected(22);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_zero_vec();
    logic [23:0] e;
    setup_job(0, NOKIL);
    res_at[6] = 1'b1;
    model_done();
    push_expected(9);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL zero_vec cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_timeout();
    logic [23:0] e;
    setup_job(2, NOKIL);
    res_at[9] = 1'b1;
    model_done();
    push_expected(34);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_early_results();
    logic [23:0] e;
    setup_job(3, NOKIL);
    res_at[6]  = 1'b1;
    res_at[7]  = 1'b1;
    res_at[12] = 1'b1;
    model_done();
    push_expected(18);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL early_res cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_abort();
    logic [23:0] e;
    setup_job(10, 11);   // cycle 11 is STREAM with A_ADDR=5
    model_done();
    push_expected(14);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
    setup_job(2, NOKIL);
    res_at[9]  = 1'b1;
    res_at[10] = 1'b1;
    model_done();
    push_expected(16);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL after_abort cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_start_abort_idle();
    logic [23:0] e;
    setup_job(5, 0);
    model_done();
    push_expected(4);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL start_abort cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_max_vec();
    logic [23:0] e;
    setup_job(255, NOKIL);
    for (int t = 7; t <= 260; t++) res_at[t] = 1'b1;
    res_at[265] = 1'b1;
    model_done();
    push_expected(270);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 270; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL max_vec cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] e;
    setup_job(3, NOKIL);
    model_done();
    push_expected(10);
    @(negedge clk);
    drive(0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs, e);
      end
      drive(c);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.res_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== 24'h0) begin
        errors++;
        $display("FAIL reset_wait cyc=%0d got=%h exp=%h", c, obs, 24'h0);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.res_valid = 1'b0;
    bus.num_vec   = 8'd0;
    test_reset();
    test_basic();
    test_zero_vec();
    test_timeout();
    test_early_results();
    test_abort();
    test_start_abort_idle();
    test_max_vec();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N rows x N columns of PEs).
REQ-002 Parameter TMO, default 4*N+8: drain timeout in cycles.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high; one clock, no other clock domains.
REQ-005 START  input  1  job request; sampled only in IDLE.
REQ-006 NUM_VEC  input  8  activation vectors in the job; latched on accepted START.
REQ-007 ABORT  input  1  synchronous job kill.
REQ-008 RES_VALID  input  1  bottom-row result valid from the array; one pulse per result vector.
REQ-009 W_RD_EN / W_ADDR  output  1 / clog2(N)  weight-row read request; read data returns 1 cycle later.
REQ-010 W_LOAD_ROW  output  N  one-hot weight-load strobe per PE row.
REQ-011 A_RD_EN / A_ADDR  output  1 / 8  activation-vector read request; read data returns 1 cycle later.
REQ-012 ARR_EN  output  1  array pipeline enable to every PE.
REQ-013 EN_LEFT  output  N  per-row activation-valid, skewed.
REQ-014 BUSY / DONE / ERR  output  1 / 1 / 1  job active / 1-cycle completion pulse / timeout flag with DONE.

Function
REQ-015 States: IDLE, LOAD_W, STREAM, DRAIN, FINISH. All transitions occur on CLK rising edge.
REQ-016 IDLE: START=1 latches NUM_VEC and moves to LOAD_W; BUSY=1 from the next cycle until the cycle after DONE.
REQ-017 LOAD_W lasts N+1 cycles. In cycle k (k=0..N-1): W_RD_EN=1, W_ADDR=k. In cycle k+1: W_LOAD_ROW=1<<k. No other W_LOAD_ROW bits are high.
REQ-018 After LOAD_W: go to STREAM if latched NUM_VEC>0; go to FINISH if NUM_VEC=0 (no activation reads, ERR=0).
REQ-019 STREAM lasts NUM_VEC cycles. In cycle j: A_RD_EN=1, A_ADDR=j (0..NUM_VEC-1). Then go to DRAIN.
REQ-020 EN_LEFT[0] = A_RD_EN delayed 1 cycle. EN_LEFT[r] = EN_LEFT[0] delayed 2r cycles, matching the 2-stage PE pipeline per column hop.
REQ-021 ARR_EN=1 from the first STREAM cycle through the last DRAIN cycle; 0 otherwise (PEs clear their pipelines when disabled).
REQ-022 Result counter (8 bit): cleared on START acceptance. Increments on RES_VALID in STREAM or DRAIN. Saturates at NUM_VEC; extra pulses are ignored. RES_VALID in other states is ignored.
REQ-023 DRAIN: go to FINISH with ERR=0 when the count reaches NUM_VEC (including a RES_VALID in the same cycle). Go to FINISH with ERR=1 if TMO cycles have elapsed since DRAIN entry without reaching NUM_VEC.
REQ-024 FINISH: DONE=1 and ERR valid for exactly one cycle, then IDLE. ERR is 0 whenever DONE=0.
REQ-025 START outside IDLE is ignored; a NUM_VEC change mid-job has no effect.
REQ-026 ABORT=1 in any non-IDLE state: go to IDLE next cycle. All request/strobe outputs, ARR_EN, EN_LEFT skew pipelines and counters clear that cycle. No DONE pulse. ABORT has priority over all other transitions.
REQ-027 START and ABORT high together in IDLE: ABORT wins and the job is not accepted.

Reset
REQ-028 RST=1 asynchronously forces IDLE. All outputs go to 0 (W_RD_EN, W_ADDR, W_LOAD_ROW, A_RD_EN, A_ADDR, ARR_EN, EN_LEFT, BUSY, DONE, ERR). Latched NUM_VEC, counters and skew pipelines clear.
REQ-029 Reset asserted mid-job abandons the job. After release, the block waits in IDLE for a new START.

Verification
REQ-030 N=4, NUM_VEC=3, START at cycle 0, RES_VALID x3 in DRAIN -> W_LOAD_ROW 0001,0010,0100,1000 in cycles 2-5; A_ADDR 0,1,2 in cycles 6-8; EN_LEFT[3] high cycles 13-15; DONE=1, ERR=0.
REQ-031 NUM_VEC=0 -> 4 weight loads, no A_RD_EN, ARR_EN never high, DONE one cycle after LOAD_W, ERR=0.
REQ-032 NUM_VEC=2, only 1 RES_VALID -> DONE with ERR=1 exactly TMO=24 cycles after DRAIN entry.
REQ-033 ABORT during STREAM at A_ADDR=5 (NUM_VEC=10) -> IDLE next cycle, all outputs 0, no DONE; a following START runs a clean job.
REQ-034 RST pulse during DRAIN -> immediate all-zero outputs; START during BUSY and a 4th RES_VALID for NUM_VEC=3 are both ignored.
REQ-035 NUM_VEC=255 -> A_ADDR reaches 254 and does not wrap; DONE after 255 results.
